spi_dac_tx: RTL and testbench

SPI master transmitter that shifts a 16-bit word out to an external DAC. It runs in SPI mode 2: SCK idles high, MOSI changes on the SCK rising edge, and the DAC samples on the falling edge. It is the output-side counterpart of the ADC SPI reader in the same clock domain. The control loop writes one word per update through a load/busy handshake and receives a one-cycle done pulse when the frame completes.

---
 rtl/spi_dac_pkg.sv | 19 +
 rtl/spi_dac_tx_if.sv | 17 +
 rtl/spi_half_tick.sv | 28 ++
 rtl/spi_dac_tx.sv | 119 +++++++++++
 tb/tb_spi_dac_tx.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_dac_pkg.sv
// Shared types and default framing constants for the SPI DAC transmitter;
// word width and timing defaults match the ADC reader in the same domain.
package spi_dac_pkg;

  localparam int WORD_BITS_DEF = 16;
  localparam int CLK_DIV_DEF   = 5;
  localparam int CS_SETUP_DEF  = 4;
  localparam int CS_HOLD_DEF   = 4;
  localparam int CS_GAP_DEF    = 8;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_dac_tx_if.sv
// Load/busy/done handshake from the control loop plus the DAC-facing SPI pins.
interface spi_dac_tx_if import spi_dac_pkg::*; #(
  parameter int WORD_BITS = WORD_BITS_DEF
) ();

  logic [WORD_BITS-1:0] data_in;
  logic                 load;
  logic                 busy;
  logic                 done;
  logic                 cs;
  logic                 sck;
  logic                 mosi;

  modport master (output data_in, load, input busy, done, cs, sck, mosi);
  modport slave  (input data_in, load, output busy, done, cs, sck, mosi);

endinterface

// File: rtl/spi_half_tick.sv
// Free-running SCK half-period tick: pulses every CLK_DIV cycles after a clear.
module spi_half_tick #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_dac_tx.sv
// SPI mode-2 master that shifts one WORD_BITS word MSB-first to a DAC per load,
// framed by CS setup/hold and a minimum CS-high gap before the next frame.
module spi_dac_tx import spi_dac_pkg::*; #(
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int CS_SETUP  = CS_SETUP_DEF,
  parameter int CS_HOLD   = CS_HOLD_DEF,
  parameter int CS_GAP    = CS_GAP_DEF
) (
  input  logic         clk,
  input  logic         rst,
  spi_dac_tx_if.slave  bus
);

  localparam int BIT_W = $clog2(WORD_BITS + 1);
  localparam int PH_W  = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_BITS - 1);
  localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(CS_GAP - 1);

  state_e               state_q;
  logic                 cs_q, sck_q, mosi_q, busy_q, done_q;
  logic [WORD_BITS-1:0] sr_q;
  logic [BIT_W-1:0]     bit_q;
  logic [PH_W-1:0]      phase_q;
  logic                 half_tick;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != SHIFT),
    .tick_o (half_tick)
  );

  // sr_q holds the bits still to be sent after the one currently on mosi.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sr_q    <= '0;
      bit_q   <= '0;
      phase_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            state_q <= SETUP;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            mosi_q  <= bus.data_in[WORD_BITS-1];
            sr_q    <= {bus.data_in[WORD_BITS-2:0], 1'b0};
            bit_q   <= '0;
            phase_q <= '0;
          end
        end
        SETUP: begin
          if (phase_q == SETUP_LAST) begin
            state_q <= SHIFT;
            sck_q   <= 1'b0;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        SHIFT: begin
          if (half_tick) begin
            if (!sck_q) begin
              sck_q <= 1'b1;
              sr_q  <= {sr_q[WORD_BITS-2:0], 1'b0};
              // The LSB stays on mosi through HOLD.
              if (bit_q != BIT_LAST) mosi_q <= sr_q[WORD_BITS-1];
            end else if (bit_q == BIT_LAST) begin
              state_q <= HOLD;
              bit_q   <= '0;
            end else begin
              sck_q <= 1'b0;
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
        HOLD: begin
          if (phase_q == HOLD_LAST) begin
            state_q <= GAP;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        GAP: begin
          if (phase_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.cs   = cs_q;
  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;

endmodule

// File: tb/tb_spi_dac_tx.sv
// Randomized bench for spi_dac_tx: default-timing and fast-timing instances,
// each frame reconstructed from the pins and compared with the loaded word.
module tb_spi_dac_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_dac_tx_if #(.WORD_BITS(16)) ia ();
  spi_dac_tx_if #(.WORD_BITS(16)) ib ();

  spi_dac_tx dut_a (.clk(clk), .rst(rst), .bus(ia));
  spi_dac_tx #(.WORD_BITS(16), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(8))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  int n_cmp = 0;
  int n_err = 0;
  int hi_run = 0;
  int viol = 0;
  bit sel = 1'b0;
  logic cs_s, sck_s, mosi_s, busy_s, done_s;

  always_comb begin
    if (sel) begin
      cs_s = ib.cs; sck_s = ib.sck; mosi_s = ib.mosi; busy_s = ib.busy; done_s = ib.done;
    end else begin
      cs_s = ia.cs; sck_s = ia.sck; mosi_s = ia.mosi; busy_s = ia.busy; done_s = ia.done;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] d);
    if (sel) begin ib.load = ld; ib.data_in = d; end
    else     begin ia.load = ld; ia.data_in = d; end
  endtask

  // Advance one clock and sample; track CS-high run length and idle-pin rules.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cs_s) begin
      hi_run++;
      if (sck_s !== 1'b1 || mosi_s !== 1'b0) viol++;
    end else begin
      hi_run = 0;
    end
  endtask

  // One whole frame from an idle DUT: expected timing from the frame formulas.
  task automatic frame(input logic [15:0] w, input bit keep, input int sp,
                       input logic [15:0] spd, input int exp_gap);
    int cd, su, ho, ga, len, falls, first, lastfall, badint, dn, b;
    logic [15:0] bits;
    logic psck;
    cd = sel ? 1 : 5; su = sel ? 1 : 4; ho = sel ? 1 : 4; ga = 8;
    if (exp_gap != 0) chk("cs_gap", hi_run, exp_gap);
    chk("idle_busy", busy_s, 0);
    drive(1'b1, w);
    tick();
    if (!keep) drive(1'b0, w);
    viol = 0;
    chk("acc_cs", cs_s, 0);
    chk("acc_busy", busy_s, 1);
    chk("acc_mosi", mosi_s, w[15]);
    len = 0; falls = 0; first = -1; lastfall = 0; badint = 0; dn = 0; bits = '0;
    psck = sck_s;
    while (cs_s == 1'b0 && len < 2000) begin
      if (done_s) dn++;
      if (busy_s !== 1'b1) badint++;
      if (psck && !sck_s) begin
        falls++;
        bits = {bits[14:0], mosi_s};
        if (first < 0) first = len;
        else if (len - lastfall != 2 * cd) badint++;
        lastfall = len;
      end
      psck = sck_s;
      if (sp != 0 && len == sp) drive(1'b1, spd);
      if (sp != 0 && len == sp + 3) drive(1'b0, spd);
      len++;
      tick();
    end
    chk("frm_timeout", len < 2000, 1);
    chk("cs_low_len", len, su + 2 * cd * 16 + ho);
    chk("sck_falls", falls, 16);
    chk("bits", bits, w);
    chk("first_fall", first, su);
    chk("shape_err", badint, 0);
    chk("done_at_rise", done_s, 1);
    b = 0;
    while (busy_s && b < 100) begin
      if (b > 0 && done_s) dn++;
      b++;
      tick();
    end
    chk("gap_busy", b, ga);
    chk("extra_done", dn, 0);
    chk("idle_pins", viol, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int falls, t, gapw;
    logic [15:0] w;
    logic psck;
    rst = 1'b1;
    ia.load = 1'b0; ia.data_in = '0;
    ib.load = 1'b0; ib.data_in = '0;
    repeat (3) tick();
    chk("rst_a_cs", ia.cs, 1);   chk("rst_a_sck", ia.sck, 1);
    chk("rst_a_mosi", ia.mosi, 0); chk("rst_a_busy", ia.busy, 0);
    chk("rst_a_done", ia.done, 0);
    chk("rst_b_cs", ib.cs, 1);   chk("rst_b_sck", ib.sck, 1);
    chk("rst_b_mosi", ib.mosi, 0); chk("rst_b_busy", ib.busy, 0);
    rst = 1'b0;
    tick();

    // Basic frame, then a frame with an ignored mid-frame load.
    sel = 1'b0;
    frame(16'hA5C3, 1'b0, 0, 16'h0000, 0);
    repeat (2) tick();
    frame(16'hA5C3, 1'b0, 60, 16'h1234, 0);

    // Load held high: second frame starts exactly CS_GAP+1 cycles after CS rises.
    repeat (3) tick();
    frame(16'h8001, 1'b1, 0, 16'h0000, 0);
    frame(16'h7FFE, 1'b1, 0, 16'h0000, 9);
    drive(1'b0, 16'h0000);
    tick();

    // Reset during the 7th bit aborts cleanly.
    drive(1'b1, 16'hA5C3);
    tick();
    drive(1'b0, 16'hA5C3);
    falls = 0; t = 0; psck = sck_s;
    while (falls < 7 && t < 500) begin
      if (psck && !sck_s) falls++;
      psck = sck_s;
      if (falls < 7) begin tick(); t++; end
    end
    chk("abort_reach", falls, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_cs", cs_s, 1);
    chk("abort_sck", sck_s, 1);
    chk("abort_mosi", mosi_s, 0);
    chk("abort_busy", busy_s, 0);
    chk("abort_done", done_s, 0);
    tick();
    chk("abort_done2", done_s, 0);
    frame(16'hFFFF, 1'b0, 0, 16'h0000, 0);

    // Reset wins over a simultaneous load.
    drive(1'b1, 16'h5555);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h5555);
    chk("rstld_busy", busy_s, 0);
    chk("rstld_cs", cs_s, 1);
    tick();
    chk("rstld_busy2", busy_s, 0);

    // Fast timing instance.
    sel = 1'b1;
    frame(16'h8001, 1'b0, 0, 16'h0000, 0);

    // Constant-level words.
    sel = 1'b0;
    frame(16'h0000, 1'b0, 0, 16'h0000, 0);
    frame(16'hFFFF, 1'b0, 0, 16'h0000, 0);

    // Random words, instances, idle spacing and spurious loads.
    for (int i = 0; i < 10; i++) begin
      sel = 1'($urandom % 2);
      w = 16'($urandom);
      gapw = $urandom_range(0, 4);
      repeat (gapw) tick();
      if ($urandom % 2 == 1)
        frame(w, 1'b0, $urandom_range(10, 30), 16'($urandom), 0);
      else
        frame(w, 1'b0, 0, 16'h0000, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
